piggy_coin_counter: RTL and testbench

Coin-deposit accumulator sitting directly downstream of the button debouncer in the piggy-bank top level. It consumes the debounced button level, classifies each press as short (deposit) or long (empty the bank), and maintains a saturating running total with goal and saturation flags. Its outputs drive the top-level `uo_out` display and status pins.

---
 rtl/piggy_coin_counter.sv | 124 ++++++++++++
 tb/tb_piggy_coin_counter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/piggy_coin_counter.sv
// Piggy-bank coin accumulator: short press deposits coin_sel value (saturating), long press empties.
// Optional PIGGY_GOAL_LOCK_EN: once goal is reached, short presses are ignored until the bank is emptied.
module piggy_coin_counter #(
    parameter int WIDTH       = 8,
    parameter int LONG_CYCLES = 1000,
    parameter int GOAL        = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn,
    input  logic [1:0]       coin_sel,
    output logic [WIDTH-1:0] total,
    output logic             deposit,
    output logic             emptied,
    output logic             goal,
    output logic             sat
);

    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [HW-1:0]    LONG_V = HW'(LONG_CYCLES);
    localparam logic [WIDTH-1:0] GOAL_V = WIDTH'(GOAL);
`ifdef PIGGY_GOAL_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    typedef enum logic [1:0] {WAIT_REL, IDLE, PRESS, HELD} state_t;

    state_t            state, state_nx;
    logic [HW-1:0]     hold_cnt, hold_cnt_nx, hold_inc;
    logic [WIDTH-1:0]  total_nx;
    logic              sat_nx, deposit_nx, emptied_nx;
    logic [3:0]        coin_val;
    logic [WIDTH:0]    sum;

    always_comb begin
        coin_val = 4'd1;
        case (coin_sel)
            2'b00:   coin_val = 4'd1;
            2'b01:   coin_val = 4'd2;
            2'b10:   coin_val = 4'd5;
            default: coin_val = 4'd10;
        endcase
    end

    // One extra bit so the carry out flags the clamp.
    assign sum      = {1'b0, total} + (WIDTH+1)'(coin_val);
    assign hold_inc = hold_cnt + 1'b1;
    assign goal     = (total >= GOAL_V);

    always_comb begin
        state_nx    = state;
        hold_cnt_nx = hold_cnt;
        total_nx    = total;
        sat_nx      = sat;
        deposit_nx  = 1'b0;
        emptied_nx  = 1'b0;
        case (state)
            WAIT_REL: begin
                hold_cnt_nx = '0;
                if (!btn) state_nx = IDLE;
            end
            IDLE: begin
                if (btn) begin
                    state_nx    = PRESS;
                    hold_cnt_nx = HW'(1);
                end else begin
                    hold_cnt_nx = '0;
                end
            end
            PRESS: begin
                if (btn) begin
                    hold_cnt_nx = hold_inc;
                    if (hold_inc == LONG_V) begin
                        total_nx   = '0;
                        sat_nx     = 1'b0;
                        emptied_nx = 1'b1;
                        state_nx   = HELD;
                    end
                end else begin
                    state_nx    = IDLE;
                    hold_cnt_nx = '0;
                    if (!(LOCK && goal)) begin
                        deposit_nx = 1'b1;
                        if (sum[WIDTH]) begin
                            total_nx = '1;
                            sat_nx   = 1'b1;
                        end else begin
                            total_nx = sum[WIDTH-1:0];
                        end
                    end
                end
            end
            HELD: begin
                // hold_cnt stays at LONG_CYCLES until release
                if (!btn) begin
                    state_nx    = IDLE;
                    hold_cnt_nx = '0;
                end
            end
            default: state_nx = WAIT_REL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= WAIT_REL;
            hold_cnt <= '0;
            total    <= '0;
            sat      <= 1'b0;
            deposit  <= 1'b0;
            emptied  <= 1'b0;
        end else begin
            state    <= state_nx;
            hold_cnt <= hold_cnt_nx;
            total    <= total_nx;
            sat      <= sat_nx;
            deposit  <= deposit_nx;
            emptied  <= emptied_nx;
        end
    end

endmodule

// File: tb/tb_piggy_coin_counter.sv
// Bench for piggy_coin_counter: press-level reference model with randomized hold lengths, coins and gaps.
module tb_piggy_coin_counter;

    localparam int WIDTH = 8;
    localparam int LONG  = 16;
    localparam int GOALV = 100;
    localparam int MAXV  = (1 << WIDTH) - 1;
`ifdef PIGGY_GOAL_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst, btn;
    logic [1:0]       coin_sel;
    logic [WIDTH-1:0] total;
    logic             deposit, emptied, goal, sat;

    int n_total = 0;
    int n_bad   = 0;
    int m_total = 0;
    bit m_sat   = 1'b0;

    piggy_coin_counter #(.WIDTH(WIDTH), .LONG_CYCLES(LONG), .GOAL(GOALV)) dut (
        .clk(clk), .rst(rst), .btn(btn), .coin_sel(coin_sel),
        .total(total), .deposit(deposit), .emptied(emptied), .goal(goal), .sat(sat)
    );

    always #5 clk = ~clk;

    function automatic int coin_value(input logic [1:0] s);
        int v;
        case (s)
            2'b00:   v = 1;
            2'b01:   v = 2;
            2'b10:   v = 5;
            default: v = 10;
        endcase
        return v;
    endfunction

    // Called at a negedge; returns at a negedge with btn low, so a following call is back-to-back.
    task automatic press(input int n, input logic [1:0] sel, input string tag);
        int  emp_cnt, emp_at, dep_cnt;
        bit  exp_dep;
        emp_cnt = 0; emp_at = -1; dep_cnt = 0;
        for (int i = 1; i <= n; i++) begin
            btn = 1'b1;
            coin_sel = 2'($urandom);
            @(negedge clk);
            if (deposit) dep_cnt++;
            if (emptied) begin
                emp_cnt++;
                emp_at = i;
                n_total++;
                if (total !== '0) begin
                    n_bad++;
                    $display("FAIL %s empty_total: got %0d want 0", tag, total);
                end
            end
        end
        btn = 1'b0;
        coin_sel = sel;
        @(negedge clk);

        exp_dep = 1'b0;
        if (n >= LONG) begin
            m_total = 0;
            m_sat   = 1'b0;
        end else if (!(LOCK && m_total >= GOALV)) begin
            exp_dep = 1'b1;
            m_total = m_total + coin_value(sel);
            if (m_total > MAXV) begin
                m_total = MAXV;
                m_sat   = 1'b1;
            end
        end

        n_total++;
        if (dep_cnt !== 0) begin
            n_bad++;
            $display("FAIL %s deposit_during_hold: got %0d want 0", tag, dep_cnt);
        end
        n_total++;
        if (emp_cnt !== ((n >= LONG) ? 1 : 0)) begin
            n_bad++;
            $display("FAIL %s emptied_count: got %0d want %0d", tag, emp_cnt, (n >= LONG) ? 1 : 0);
        end
        if (n >= LONG) begin
            n_total++;
            if (emp_at !== LONG) begin
                n_bad++;
                $display("FAIL %s emptied_cycle: got %0d want %0d", tag, emp_at, LONG);
            end
        end
        n_total++;
        if (deposit !== exp_dep) begin
            n_bad++;
            $display("FAIL %s deposit: got %0b want %0b", tag, deposit, exp_dep);
        end
        n_total++;
        if (emptied !== 1'b0) begin
            n_bad++;
            $display("FAIL %s emptied_on_release: got %0b want 0", tag, emptied);
        end
        n_total++;
        if (total !== WIDTH'(m_total)) begin
            n_bad++;
            $display("FAIL %s total: got %0d want %0d", tag, total, m_total);
        end
        n_total++;
        if (sat !== m_sat) begin
            n_bad++;
            $display("FAIL %s sat: got %0b want %0b", tag, sat, m_sat);
        end
        n_total++;
        if (goal !== (m_total >= GOALV)) begin
            n_bad++;
            $display("FAIL %s goal: got %0b want %0b", tag, goal, m_total >= GOALV);
        end
    endtask

    task automatic idle(input int k, input string tag);
        btn = 1'b0;
        repeat (k) begin
            @(negedge clk);
            n_total++;
            if (deposit !== 1'b0 || emptied !== 1'b0) begin
                n_bad++;
                $display("FAIL %s idle_pulse: got dep=%0b emp=%0b want 0 0", tag, deposit, emptied);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; btn = 1'b0; coin_sel = 2'b00;
        repeat (2) @(negedge clk);
        n_total++;
        if (total !== '0 || deposit !== 1'b0 || emptied !== 1'b0 || goal !== 1'b0 || sat !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: got t=%0d d=%0b e=%0b g=%0b s=%0b want all 0",
                     total, deposit, emptied, goal, sat);
        end
        rst = 1'b0;
        m_total = 0; m_sat = 1'b0;
        idle(2, "reset");
    endtask

    task automatic test_short_deposit();
        press(5, 2'b10, "short");
        idle(1, "short_after");
    endtask

    task automatic test_long_boundary();
        press(LONG - 1, 2'b00, "hold15");
        idle(1, "hold15_after");
        press(LONG, 2'b11, "hold16");
        press(1, 2'b10, "refill");
        press(40, 2'b11, "hold40");
        idle(1, "hold40_after");
    endtask

    task automatic test_saturation();
        press(LONG + 2, 2'b00, "sat_clear");
        for (int i = 0; i < 26; i++) press(1, 2'b11, "sat_fill");
        press(2, 2'b00, "sat_plus1");
        press(LONG, 2'b00, "sat_empty");
    endtask

    task automatic test_goal();
        for (int i = 0; i < 10; i++) press(2, 2'b11, "goal");
    endtask

    task automatic test_lock();
        press(3, 2'b11, "lock_dep10");
        press(LONG + 3, 2'b00, "lock_empty");
        press(2, 2'b10, "lock_dep5");
    endtask

    task automatic test_reset_hold();
        int dep_cnt, emp_cnt;
        dep_cnt = 0; emp_cnt = 0;
        btn = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (deposit) dep_cnt++;
            if (emptied) emp_cnt++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_total = 0; m_sat = 1'b0;
        repeat (2000) begin
            coin_sel = 2'($urandom);
            @(negedge clk);
            if (deposit) dep_cnt++;
            if (emptied) emp_cnt++;
        end
        btn = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (deposit) dep_cnt++;
            if (emptied) emp_cnt++;
        end
        n_total++;
        if (dep_cnt !== 0 || emp_cnt !== 0) begin
            n_bad++;
            $display("FAIL rst_hold_pulses: got dep=%0d emp=%0d want 0 0", dep_cnt, emp_cnt);
        end
        n_total++;
        if (total !== '0) begin
            n_bad++;
            $display("FAIL rst_hold_total: got %0d want 0", total);
        end
        press(3, 2'b01, "rst_hold_fresh");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            press($urandom_range(1, LONG + 4), 2'($urandom), "random");
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3), "random_gap");
        end
    endtask

    initial begin
        test_reset();
        test_short_deposit();
        test_long_boundary();
        test_saturation();
        test_goal();
        test_lock();
        test_reset_hold();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
